// File: rtl/qos_egress_sched_if.sv
// rtl/qos_egress_sched_if.sv - QoS FIFO drain, egress stream and counter-read bundle
interface qos_egress_sched_if;
   logic [11:0] fifo_dataout0;
   logic [11:0] fifo_dataout1;
   logic [11:0] fifo_dataout2;
   logic [11:0] fifo_dataout3;
   logic [3:0]  fifo_empty;
   logic [3:0]  fifo_aempty;
   logic        popBP0;
   logic        popBP1;
   logic        popBP2;
   logic        popBP3;
   logic [11:0] data_out;
   logic        valid_out;
   logic        out_ready;
   logic        req;
   logic [2:0]  idx;
   logic        cnt_valid;
   logic [7:0]  cnt_data;

   modport master (
      input  fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3,
      input  fifo_empty, fifo_aempty, out_ready, req, idx,
      output popBP0, popBP1, popBP2, popBP3, data_out, valid_out, cnt_valid, cnt_data
   );

   modport slave (
      output fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3,
      output fifo_empty, fifo_aempty, out_ready, req, idx,
      input  popBP0, popBP1, popBP2, popBP3, data_out, valid_out, cnt_valid, cnt_data
   );
endinterface

// File: rtl/qos_egress_sched.sv
// rtl/qos_egress_sched.sv - WRR drain of four QoS FIFOs into one buffered egress stream
// Per-class served counters are readable one cycle after req.
module qos_egress_sched #(
   parameter int W0 = 4,
   parameter int W1 = 3,
   parameter int W2 = 2,
   parameter int W3 = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init,
   qos_egress_sched_if.master bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SERVE  = 2'd1;
   localparam logic [1:0] S_SWITCH = 2'd2;

   logic [1:0]  state;
   logic [1:0]  cls;
   logic [1:0]  start;
   logic [1:0]  next_cls;
   logic [3:0]  qcnt;
   logic [3:0]  quantum;
   logic        served;
   logic [3:0]  pend;
   logic [3:0]  elig;
   logic [3:0]  last_pop;
   logic [3:0]  pop;
   logic        inflight;
   logic        room;
   logic        q_done;
   logic [11:0] mem [3];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   logic [1:0]  occ;
   logic [11:0] wr_data;
   logic        rd_en;
   logic [7:0]  cnt [4];
   logic        cnt_valid_q;
   logic [7:0]  cnt_data_q;

   assign pend     = ~bus.fifo_empty;
   assign elig     = pend & (~bus.fifo_aempty | ~last_pop);
   assign inflight = |last_pop;
   assign room     = ({1'b0, occ} + {2'b00, inflight}) < 3'd3;

   always_comb begin
      pop = 4'b0000;
      if (state == S_SERVE && elig[cls] && room && !init)
         pop[cls] = 1'b1;
   end

   assign bus.popBP0 = pop[0];
   assign bus.popBP1 = pop[1];
   assign bus.popBP2 = pop[2];
   assign bus.popBP3 = pop[3];

   always_comb begin
      case (cls)
         2'd0:    quantum = 4'(W0);
         2'd1:    quantum = 4'(W1);
         2'd2:    quantum = 4'(W2);
         default: quantum = 4'(W3);
      endcase
   end

   assign q_done = (|pop) && (qcnt + 4'd1 == quantum);

   // IDLE and SWITCH never pop, so in the following SERVE cycle a non-empty FIFO is eligible:
   // selection therefore only needs ~empty. The search wraps back to cls last.
   always_comb begin
      start    = (state == S_IDLE && !served) ? cls : cls + 2'd1;
      next_cls = start;
      for (int i = 3; i >= 0; i--)
         if (pend[start + 2'(i)])
            next_cls = start + 2'(i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cls      <= 2'd0;
         qcnt     <= 4'd0;
         served   <= 1'b0;
         last_pop <= 4'b0000;
      end else if (init) begin
         state    <= S_IDLE;
         cls      <= 2'd0;
         qcnt     <= 4'd0;
         served   <= 1'b0;
         last_pop <= 4'b0000;
      end else begin
         last_pop <= pop;
         case (state)
            S_IDLE: begin
               if (|pend) begin
                  state  <= S_SERVE;
                  cls    <= next_cls;
                  qcnt   <= 4'd0;
                  served <= 1'b1;
               end
            end
            S_SERVE: begin
               if (|pop)
                  qcnt <= qcnt + 4'd1;
               if (q_done || !elig[cls])
                  state <= S_SWITCH;
            end
            S_SWITCH: begin
               qcnt <= 4'd0;
               if (|pend) begin
                  state <= S_SERVE;
                  cls   <= next_cls;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read data arrives the cycle after the pop; last_pop says which FIFO it came from.
   assign wr_data = ({12{last_pop[0]}} & bus.fifo_dataout0) |
                    ({12{last_pop[1]}} & bus.fifo_dataout1) |
                    ({12{last_pop[2]}} & bus.fifo_dataout2) |
                    ({12{last_pop[3]}} & bus.fifo_dataout3);
   assign rd_en   = (occ != 2'd0) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (inflight)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         occ    <= 2'd0;
      end else if (init) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         occ    <= 2'd0;
      end else begin
         if (inflight)
            wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
         if (rd_en)
            rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
         occ <= occ + {1'b0, inflight} - {1'b0, rd_en};
      end
   end

   assign bus.valid_out = (occ != 2'd0);
   assign bus.data_out  = (occ != 2'd0) ? mem[rd_ptr] : 12'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < 4; n++)
            cnt[n] <= 8'd0;
         cnt_valid_q <= 1'b0;
         cnt_data_q  <= 8'd0;
      end else if (init) begin
         for (int n = 0; n < 4; n++)
            cnt[n] <= 8'd0;
         cnt_valid_q <= 1'b0;
         cnt_data_q  <= 8'd0;
      end else begin
         for (int n = 0; n < 4; n++)
            if (pop[n])
               cnt[n] <= cnt[n] + 8'd1;
         cnt_valid_q <= bus.req;
         cnt_data_q  <= (bus.req && !bus.idx[2]) ? cnt[bus.idx[1:0]] : 8'd0;
      end
   end

   assign bus.cnt_valid = cnt_valid_q;
   assign bus.cnt_data  = cnt_data_q;
endmodule

// File: tb/tb_qos_egress_sched.sv
// tb/tb_qos_egress_sched.sv - scoreboard bench with turn-level WRR reference model
module tb_qos_egress_sched;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic init = 1'b0;
   always #5 clk = ~clk;

   qos_egress_sched_if bus();
   qos_egress_sched dut (.clk(clk), .reset(reset), .init(init), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [11:0] fmem [4][512];
   int fhd [4];
   int ftl [4];
   logic [11:0] exp_data [$];
   int exp_cls [$];
   int plan_q [$];
   int pop_cyc [$];
   int mcnt [4];
   int wt [4] = '{4, 3, 2, 1};
   int mc = 0;
   bit mfresh = 1'b1;
   int cyc = 0;
   int npop = 0;
   int first_pop_cyc = -1;
   int first_valid_cyc = -1;
   int ready_mode = 0;
   bit hold_v = 1'b0;
   logic [11:0] hold_d;
   logic [3:0] pops;
   logic [3:0] lastp = 4'b0000;
   int sz;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic set_dout(input int n, input logic [11:0] v);
      case (n)
         0: bus.fifo_dataout0 = v;
         1: bus.fifo_dataout1 = v;
         2: bus.fifo_dataout2 = v;
         default: bus.fifo_dataout3 = v;
      endcase
   endtask

   // Behavioural FIFOs, pop/egress monitor and scoreboard.
   always begin
      @(negedge clk);
      cyc++;
      pops = {bus.popBP3, bus.popBP2, bus.popBP1, bus.popBP0};
      if (pops != 4'b0000) begin
         check("single_pop", $countones(pops), 1);
         for (int n = 0; n < 4; n++) begin
            if (pops[n]) begin
               sz = ftl[n] - fhd[n];
               check("pop_nonempty", int'(sz > 0), 1);
               check("pop_no_underflow", int'(sz == 1 && lastp[n]), 0);
               if (exp_cls.size() == 0) check("pop_unexpected", n, -1);
               else check("pop_class", n, exp_cls.pop_front());
               if (sz > 0) exp_data.push_back(fmem[n][fhd[n]]);
               mcnt[n] = (mcnt[n] + 1) % 256;
               npop++;
               pop_cyc.push_back(cyc);
               if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
         end
      end
      lastp = pops;
      if (hold_v) begin
         check("hold_valid", int'(bus.valid_out), 1);
         check("hold_data", int'(bus.data_out), int'(hold_d));
      end
      hold_v = 1'b0;
      if (bus.valid_out) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.out_ready) begin
            if (exp_data.size() == 0) check("egress_unexpected", int'(bus.data_out), -1);
            else check("egress_data", int'(bus.data_out), int'(exp_data.pop_front()));
         end else begin
            hold_v = 1'b1;
            hold_d = bus.data_out;
         end
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
         if (pops[n] && ftl[n] > fhd[n]) begin
            set_dout(n, fmem[n][fhd[n]]);
            fhd[n]++;
         end
         bus.fifo_empty[n]  = (ftl[n] - fhd[n]) == 0;
         bus.fifo_aempty[n] = (ftl[n] - fhd[n]) <= 1;
      end
      bus.out_ready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic load(input int n, input int k);
      if (ftl[n] == fhd[n]) begin
         fhd[n] = 0;
         ftl[n] = 0;
      end
      repeat (k) begin
         fmem[n][ftl[n]] = 12'($urandom);
         ftl[n]++;
      end
   endtask

   // Turn-level WRR: each turn visits the next non-empty class after the last one served and
   // pops up to its weight, stopping early when a pop leaves exactly one word (aempty guard).
   task automatic plan();
      int rem [4];
      int s;
      int c;
      int p;
      bit found;
      for (int n = 0; n < 4; n++) rem[n] = ftl[n] - fhd[n];
      plan_q.delete();
      while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
         s = mfresh ? mc : (mc + 1) % 4;
         found = 1'b0;
         c = s;
         for (int i = 0; i < 4; i++) begin
            if (!found && rem[(s + i) % 4] > 0) begin
               c = (s + i) % 4;
               found = 1'b1;
            end
         end
         mc = c;
         mfresh = 1'b0;
         p = 0;
         do begin
            exp_cls.push_back(c);
            plan_q.push_back(c);
            rem[c]--;
            p++;
         end while (p < wt[c] && rem[c] > 1);
      end
   endtask

   task automatic arm();
      npop = 0;
      pop_cyc.delete();
      first_pop_cyc = -1;
      first_valid_cyc = -1;
   endtask

   task automatic scen_init(input int c0, input int c1, input int c2, input int c3, input int mode);
      @(posedge clk);
      #2;
      ready_mode = mode;
      init = 1'b1;
      bus.req = 1'b1;
      bus.idx = 3'd2;
      mcnt = '{0, 0, 0, 0};
      mc = 0;
      mfresh = 1'b1;
      load(0, c0); load(1, c1); load(2, c2); load(3, c3);
      plan();
      arm();
      @(posedge clk);
      #2;
      check("init_beats_req", int'(bus.cnt_valid), 0);
      bus.req = 1'b0;
      @(posedge clk);
      #2;
      init = 1'b0;
   endtask

   task automatic scen_load(input int c0, input int c1, input int c2, input int c3, input int mode);
      @(posedge clk);
      #2;
      ready_mode = mode;
      load(0, c0); load(1, c1); load(2, c2); load(3, c3);
      plan();
      arm();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (((ftl[0] - fhd[0]) + (ftl[1] - fhd[1]) + (ftl[2] - fhd[2]) + (ftl[3] - fhd[3]) > 0 ||
              exp_data.size() > 0 || exp_cls.size() > 0) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check("drain_in_time", int'(t < 4000), 1);
      check("plan_consumed", exp_cls.size(), 0);
   endtask

   task automatic read_cnt(input int i, input int expv);
      @(posedge clk);
      #2;
      bus.req = 1'b1;
      bus.idx = 3'(i);
      @(posedge clk);
      #2;
      bus.req = 1'b0;
      check("cnt_valid", int'(bus.cnt_valid), 1);
      check("cnt_data", int'(bus.cnt_data), expv);
      @(posedge clk);
      #2;
      check("cnt_valid_idle", int'(bus.cnt_valid), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int rel;
      int a [4];
      int ri;
      bus.out_ready = 1'b1;
      bus.req = 1'b0;
      bus.idx = 3'd0;
      bus.fifo_empty = 4'hf;
      bus.fifo_aempty = 4'hf;
      for (int n = 0; n < 4; n++) begin
         fhd[n] = 0;
         ftl[n] = 0;
         mcnt[n] = 0;
         set_dout(n, 12'd0);
      end

      // Reset with FIFO0 holding five words, then the release latency and the 4+1 pattern.
      load(0, 5);
      mc = 0;
      mfresh = 1'b1;
      plan();
      repeat (3) @(negedge clk);
      check("rst_pop", int'({bus.popBP3, bus.popBP2, bus.popBP1, bus.popBP0}), 0);
      check("rst_valid", int'(bus.valid_out), 0);
      check("rst_data", int'(bus.data_out), 0);
      check("rst_cnt_valid", int'(bus.cnt_valid), 0);
      check("rst_cnt_data", int'(bus.cnt_data), 0);
      @(posedge clk);
      #2;
      arm();
      reset = 1'b1;
      rel = cyc;
      drain();
      check("first_pop_latency", first_pop_cyc - rel, 2);
      check("first_word_latency", first_valid_cyc - first_pop_cyc, 2);
      check("w0_pop_count", pop_cyc.size(), 5);
      if (pop_cyc.size() >= 5) begin
         check("w0_back_to_back", pop_cyc[3] - pop_cyc[0], 3);
         check("w0_one_bubble", pop_cyc[4] - pop_cyc[0], 5);
      end

      // All classes deep: 0000-111-22-3 with one bubble per switch.
      scen_init(9, 9, 9, 9, 0);
      drain();
      if (pop_cyc.size() >= 10 && plan_q.size() >= 10)
         for (int i = 1; i < 10; i++)
            check("switch_gap", pop_cyc[i] - pop_cyc[i - 1], (plan_q[i] == plan_q[i - 1]) ? 1 : 2);
      else
         check("deep_pop_count", pop_cyc.size(), 36);

      // Backpressure: three pops fill buffer plus in-flight slot, data held.
      scen_init(0, 8, 0, 0, 1);
      repeat (12) @(negedge clk);
      check("stall_pops", npop, 3);
      ready_mode = 0;
      drain();
      check("stall_total_pops", npop, 8);

      // Single-word FIFO.
      scen_init(0, 0, 1, 0, 0);
      drain();
      check("one_word_pops", npop, 1);

      // Counter reads and wrap.
      scen_init(0, 0, 7, 0, 2);
      drain();
      read_cnt(2, mcnt[2]);
      read_cnt(5, 0);
      read_cnt(0, mcnt[0]);
      scen_load(0, 0, 249, 0, 0);
      drain();
      read_cnt(2, mcnt[2]);

      // Randomised traffic, alternating fresh (init) and continued scheduling.
      for (int r = 0; r < 6; r++) begin
         for (int n = 0; n < 4; n++) a[n] = $urandom_range(0, 10);
         if (r % 2 == 0) scen_init(a[0], a[1], a[2], a[3], 2);
         else scen_load(a[0], a[1], a[2], a[3], 2);
         drain();
         ri = $urandom_range(0, 7);
         read_cnt(ri, (ri < 4) ? mcnt[ri] : 0);
      end

      // Async reset in the middle of traffic.
      scen_init(10, 10, 10, 10, 2);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("midrst_pop", int'({bus.popBP3, bus.popBP2, bus.popBP1, bus.popBP0}), 0);
      check("midrst_valid", int'(bus.valid_out), 0);
      check("midrst_cnt_data", int'(bus.cnt_data), 0);
      for (int n = 0; n < 4; n++) begin
         fhd[n] = 0;
         ftl[n] = 0;
         mcnt[n] = 0;
      end
      exp_data.delete();
      exp_cls.delete();
      hold_v = 1'b0;
      mc = 0;
      mfresh = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      scen_load($urandom_range(1, 8), $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8), 2);
      drain();
      read_cnt(1, mcnt[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
